// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide engine.
// One radix-2 step per clock (shift-add multiply, restoring divide) on operand
// magnitudes, followed by one sign-fixup cycle. Latency is fixed at WIDTH+1
// cycles from the accepting edge to the done pulse, independent of operands.
// Ports:
//   clk     rising-edge clock
//   reset   synchronous active-high reset (aborts any operation in flight)
//   start   request, sampled only while idle
//   funct3  RV32M op select (000 MUL .. 111 REMU), sampled with start
//   a, b    rs1 / rs2 operands, sampled with start
//   result  registered result, updated only in the done cycle (or cleared by reset)
//   busy    high while an operation is in flight
//   done    one-cycle completion pulse, result valid in the same cycle
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;     // multiplicand / dividend shift register
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;     // multiplier shift register / divisor
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;     // original rs1, needed for REM by zero
  logic [2*WIDTH-1:0] acc_q, acc_d;         // product, or {remainder, quotient}
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div0_q, div0_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;

  logic               signed_a, signed_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_part;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_result;

  // Which operands are interpreted as signed for the incoming funct3.
  always_comb begin
    signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  end

  // Sign correction and result selection, consumed in the FIX cycle.
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    case (op_q)
      3'b000:                 fix_result = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_result = quot_fix;
      default:                fix_result = rem_fix;
    endcase
    if (div0_q) begin
      fix_result = op_q[1] ? a_raw_q : '1;
    end else if (ovf_q) begin
      fix_result = op_q[1] ? '0 : MOST_NEG;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    a_raw_d  = a_raw_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    done_d   = 1'b0;

    // Multiply step: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole (carry, acc) right by one.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_mag_q[0] ? {1'b0, a_mag_q} : '0);
    // Divide step: bring the next dividend bit into the partial remainder and
    // trial-subtract; a set MSB on the difference means the subtract failed.
    div_part = {acc_q[2*WIDTH-1:WIDTH], a_mag_q[WIDTH-1]};
    div_diff = div_part - {1'b0, b_mag_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CALC;
          op_d     = funct3;
          sign_a_d = signed_a & a[WIDTH-1];
          sign_b_d = signed_b & b[WIDTH-1];
          a_mag_d  = (signed_a & a[WIDTH-1]) ? -a : a;
          b_mag_d  = (signed_b & b[WIDTH-1]) ? -b : b;
          a_raw_d  = a;
          acc_d    = '0;
          cnt_d    = '0;
          div0_d   = funct3[2] && (b == '0);
          ovf_d    = (funct3 == 3'b100 || funct3 == 3'b110) &&
                     (a == MOST_NEG) && (b == '1);
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          if (!div_diff[WIDTH]) begin
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
          a_mag_d = a_mag_q << 1;
        end else begin
          acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
          b_mag_d = b_mag_q >> 1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_result;
        done_d   = 1'b1;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      a_raw_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      a_raw_q  <= a_raw_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) behind a start/busy/done handshake. It sits beside the single-cycle `alu` as the first multi-cycle execution resource. The planned multicycle/pipelined core stalls on `busy` and writes back `result` on `done`. Latency is fixed regardless of operand values.

## Interface
- `WIDTH`, default 32: operand and result width in bits; any value ≥ 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `funct3`  in  3  operation select, RV32M encoding, sampled with `start`:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a`  in  WIDTH  rs1 operand, sampled with `start`.
- `b`  in  WIDTH  rs2 operand, sampled with `start`.
- `result`  out  WIDTH  registered result; holds until the next completion or reset.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle completion pulse; `result` is valid in the same cycle.

## Operation
- FSM states:
  - IDLE: `start`=1 → CALC; `start`=0 → IDLE.
  - CALC: iteration counter 0..WIDTH-1; after the iteration with counter = WIDTH-1 → FIX.
  - FIX: → IDLE unconditionally.
- Acceptance (IDLE & `start`):
  - Latch op, operand signs and operand magnitudes; clear the 2·WIDTH accumulator and the counter.
  - Signed operand: MULH (a, b), MULHSU (a only), DIV/REM (a, b). All other operands are unsigned.
  - Magnitude = two's-complement negation of a signed operand whose MSB is set; otherwise the operand unchanged.
- Multiply (CALC): radix-2 shift-add on magnitudes, one multiplier bit per cycle, building a 2·WIDTH product.
- Divide (CALC): restoring division on magnitudes, one quotient bit per cycle. Produces a WIDTH-bit quotient and a WIDTH-bit remainder.
- FIX, sign correction:
  - Product is negated if sign_a ^ sign_b.
  - Quotient is negated if sign_a ^ sign_b.
  - Remainder takes the sign of a.
- FIX, result select:
  - MUL → product[WIDTH-1:0].
  - MULH/MULHSU/MULHU → product[2·WIDTH-1:WIDTH].
  - DIV/DIVU → quotient; REM/REMU → remainder.
- Special cases: flagged at acceptance, override in FIX, latency unchanged.
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow (a = most-negative, b = all ones, DIV/REM only): DIV → a; REM → 0.
- All arithmetic is modulo 2^WIDTH (product modulo 2^(2·WIDTH)); no exceptions or flags.

## Timing
- Reset (synchronous, takes priority over everything including `start`):
  - state=IDLE, `busy`=0, `done`=0, `result`=0, counter=0.
  - Reset mid-operation aborts the operation; no `done` is produced.
- Edge E accepts `start`:
  - `busy`=1 from E.
  - CALC iterations occur at edges E+1..E+WIDTH.
  - At edge E+WIDTH+1 (FIX→IDLE): `result` updates, `done`=1, `busy`=0.
- Latency: `done` is visible WIDTH+1 cycles after the accepting edge (33 for WIDTH=32).
- `done` is high for exactly one cycle.
- `busy` and `done` are never high together.
- `start` while `busy`=1 is ignored. It is not queued, and operands/funct3 changes while busy have no effect.
- `start` high in the `done` cycle is accepted (state is IDLE), giving back-to-back operations with zero idle cycles.
- `result` is stable between completions; it changes only in the `done` cycle or on reset.

## Test plan
- Reset then idle, WIDTH=32: `result`=0, `busy`=0, `done`=0.
  - Then MUL a=7, b=0xFFFFFFFD → `result`=0xFFFFFFEB, `done` exactly 33 cycles after the accepting edge, `busy` high for 33 cycles.
- High-half multiplies, WIDTH=32:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Signed/unsigned divide, WIDTH=32:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC; REMU → 1.
- Special cases, WIDTH=32:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 5/0 → 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - All complete with latency 33.
- Handshake, WIDTH=32:
  - Pulse `start` with a DIV mid-MUL → ignored; the MUL result is correct.
  - Hold `start` through the `done` cycle → second op accepted that edge, its `done` 33 cycles later.
  - Assert `reset` at CALC iteration 10 → `busy`=0, `result`=0 next cycle, no `done` pulse.
- WIDTH=8 instance:
  - MUL 0x0F×0x11 → 0xFF; MULHU 0xFF×0xFF → 0xFE; DIV 0x80/0xFF → 0x80.
  - `done` 9 cycles after acceptance.
